// File: rtl/uart_rx_engine.sv
// UART receive engine: 2-flop synchronizer, baud tick divider, oversampled
// frame FSM (start/data/parity/stop) and a single-entry holding register.
module uart_rx_engine #(
  parameter int BITWIDTH   = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  input  logic                rx,
  input  logic [7:0]          baud_val,
  input  logic                parity_en,
  input  logic                parity_odd,
  input  logic                rd_en,
  output logic [BITWIDTH-1:0] rx_data,
  output logic                rx_rdy,
  output logic                parity_err,
  output logic                framing_err,
  output logic                overflow
);

  localparam int SCW = $clog2(OVERSAMPLE + 1);
  localparam int BCW = $clog2(BITWIDTH + 1);
  localparam logic [SCW-1:0] SAMP_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SAMP_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(BITWIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic                rx_meta_q, rx_meta_d;
  logic                rx_sync_q, rx_sync_d;
  logic                rx_prev_q, rx_prev_d;
  logic [7:0]          baud_cnt_q, baud_cnt_d;
  logic [7:0]          baud_lat_q, baud_lat_d;
  logic                tick;
  state_e              state_q, state_d;
  logic [SCW-1:0]      samp_cnt_q, samp_cnt_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [BITWIDTH-1:0] shift_q, shift_d;
  logic                par_bad_q, par_bad_d;
  logic                done;
  logic                frame_ferr;
  logic                samp_hit;
  logic [BITWIDTH-1:0] rx_data_q, rx_data_d;
  logic                rx_rdy_q, rx_rdy_d;
  logic                parity_err_q, parity_err_d;
  logic                framing_err_q, framing_err_d;
  logic                overflow_q, overflow_d;

  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  // The divisor is latched on every wrap so a mid-count change cannot
  // strand the counter above the new terminal value.
  always_comb begin
    tick       = (baud_cnt_q == baud_lat_q);
    baud_cnt_d = baud_cnt_q + 8'd1;
    baud_lat_d = baud_lat_q;
    if (tick) begin
      baud_cnt_d = '0;
      baud_lat_d = baud_val;
    end
  end

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    done       = 1'b0;
    frame_ferr = 1'b0;
    samp_hit   = tick && (samp_cnt_q == SAMP_LAST);

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          samp_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          if (samp_cnt_q == SAMP_MID) begin
            samp_cnt_d = '0;
            if (!rx_sync_q) begin
              bit_cnt_d = '0;
              par_bad_d = 1'b0;
              state_d   = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (samp_hit) begin
          samp_cnt_d = '0;
          shift_d    = {rx_sync_q, shift_q[BITWIDTH-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = parity_en ? PARITY : STOP;
          end
        end else if (tick) begin
          samp_cnt_d = samp_cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (samp_hit) begin
          samp_cnt_d = '0;
          par_bad_d  = ((^shift_q) ^ rx_sync_q) != parity_odd;
          state_d    = STOP;
        end else if (tick) begin
          samp_cnt_d = samp_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (samp_hit) begin
          samp_cnt_d = '0;
          done       = 1'b1;
          frame_ferr = !rx_sync_q;
          state_d    = IDLE;
        end else if (tick) begin
          samp_cnt_d = samp_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A read coinciding with completion hands the slot straight to the new
  // frame, so rx_rdy stays high and no overflow is recorded.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_rdy_d      = rx_rdy_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;
    if (done) begin
      if (!rx_rdy_q || rd_en) begin
        rx_data_d     = shift_q;
        parity_err_d  = par_bad_q;
        framing_err_d = frame_ferr;
        rx_rdy_d      = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (rd_en && rx_rdy_q) begin
      rx_rdy_d      = 1'b0;
      parity_err_d  = 1'b0;
      framing_err_d = 1'b0;
      overflow_d    = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      baud_cnt_q    <= '0;
      baud_lat_q    <= '0;
      state_q       <= IDLE;
      samp_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_bad_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_rdy_q      <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rx_sync_q     <= rx_sync_d;
      rx_prev_q     <= rx_prev_d;
      baud_cnt_q    <= baud_cnt_d;
      baud_lat_q    <= baud_lat_d;
      state_q       <= state_d;
      samp_cnt_q    <= samp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_bad_q     <= par_bad_d;
      rx_data_q     <= rx_data_d;
      rx_rdy_q      <= rx_rdy_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_rdy      = rx_rdy_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud ticks per bit.
REQ-003 SHALL have port PCLK, input, 1, sole clock; all logic is rising-edge.
REQ-004 SHALL have port PRESETN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port baud_val, input, 8, divisor; one oversample tick every baud_val+1 PCLK cycles.
REQ-007 SHALL have port parity_en, input, 1, 1 = frame carries a parity bit.
REQ-008 SHALL have port parity_odd, input, 1, 1 = odd parity, 0 = even parity.
REQ-009 SHALL have port rd_en, input, 1, consumer read strobe for the holding register.
REQ-010 SHALL have port rx_data, output, BITWIDTH, holding-register contents.
REQ-011 SHALL have port rx_rdy, output, 1, holding register holds unread data.
REQ-012 SHALL have port parity_err, output, 1, parity error of the held frame.
REQ-013 SHALL have port framing_err, output, 1, stop bit of the held frame sampled 0.
REQ-014 SHALL have port overflow, output, 1, sticky flag: a completed frame was dropped.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value.
REQ-016 Tick counter SHALL count 0..baud_val and pulse tick for one cycle when count==baud_val, then wrap to 0; baud_val=0 gives a tick every cycle; a baud_val change takes effect at the next wrap.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: on a synchronized 1->0 transition SHALL clear the sample counter and go to START.
REQ-019 START: at the 8th tick (sample count 7), the line SHALL be re-sampled; 0 -> clear the sample counter and go to DATA; 1 -> false start, return to IDLE with no flags changed.
REQ-020 DATA: SHALL sample one bit every OVERSAMPLE ticks, LSB first, shifting into a BITWIDTH shift register; after bit BITWIDTH-1, go to PARITY if parity_en else STOP.
REQ-021 PARITY: SHALL sample one bit after OVERSAMPLE ticks; error = (XOR of data bits XOR parity bit) != parity_odd.
REQ-022 STOP: SHALL sample after OVERSAMPLE ticks; 0 -> framing error for this frame; then return to IDLE on the same cycle (no stop-bit tail wait).
REQ-023 Frame completion SHALL occur on the stop-sample tick; the holding register, parity_err and framing_err update on the next PCLK edge and rx_rdy rises on that edge.
REQ-024 Completion with rx_rdy=0 SHALL load rx_data, parity_err and framing_err and set rx_rdy.
REQ-025 Completion with rx_rdy=1 and rd_en=0 SHALL discard the new frame, keep old rx_data and flags, and set overflow.
REQ-026 Completion with rx_rdy=1 and rd_en=1 on the same cycle SHALL load the new frame, keep rx_rdy=1, and leave overflow unchanged.
REQ-027 rd_en with rx_rdy=1 and no completion SHALL clear rx_rdy, parity_err, framing_err and overflow on the next edge; rx_data holds its value.
REQ-028 rd_en with rx_rdy=0 SHALL have no effect.
REQ-029 parity_en and parity_odd SHALL be sampled at each use; changing them mid-frame is undefined and need not be checked.
REQ-030 The data path SHALL not stall: frames back-to-back (a start edge directly after a stop sample) SHALL be received.

Reset
REQ-031 PRESETN low SHALL immediately force FSM=IDLE, all counters=0, shift register=0, rx_data=0, rx_rdy=0, parity_err=0, framing_err=0, overflow=0, synchronizer flops=1.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release, reception restarts only on a new falling edge.

Verification
REQ-033 baud_val=0, parity off, frame 0xA5 with stop=1 -> rx_data=0xA5, rx_rdy=1, parity_err=0, framing_err=0, rx_rdy rises 1 cycle after stop-sample tick (~2+8+16*9 PCLK after the start edge).
REQ-034 baud_val=3, parity on, even, send 0x3C with parity bit 1 -> rx_data=0x3C, parity_err=1; pulse rd_en -> rx_rdy=0, parity_err=0.
REQ-035 Send 0x55 with stop=0 -> framing_err=1, rx_data=0x55; next frame 0x01 with valid stop, no read -> overflow=1, rx_data stays 0x55.
REQ-036 Glitch low for 4 ticks (< 8) on idle line -> FSM returns to IDLE, rx_rdy stays 0, no flags set.
REQ-037 rd_en asserted on the exact completion cycle of a second frame 0x7E while 0x11 is held -> rx_data=0x7E, rx_rdy=1, overflow=0.
REQ-038 PRESETN pulsed low during DATA bit 4 -> all outputs 0 at once; the following clean frame 0xC3 is received correctly.
